// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect, MDU wait, data-memory wait.
// Control outputs are combinational from the registered state and current inputs.
//
// state    | meaning
// RUN      | normal issue; hazards resolved in one cycle
// MEM_WAIT | data memory access outstanding, whole pipe held
// MDU_WAIT | multi-cycle mul/div in EX, front end held, bubbles into EX/MEM
// ERR      | memory timed out; pipe frozen until reset
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_wen,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_access,
  input  logic             mem_resp_valid,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_bubble,
  output logic             mem_req,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  // Down-counter: cycles left in MEM_WAIT before the timeout fires at zero.
  localparam logic [TO_W-1:0] WAIT_LOAD = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_left_q, wait_left_d;
  logic            timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic            load_use;

  assign load_use = ex_is_load && ex_reg_wen && (ex_rd_addr != 5'd0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    state_d       = state_q;
    wait_left_d   = wait_left_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_req       = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (mem_access && !mem_resp_valid) begin
            mem_req      = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_d      = MEM_WAIT;
            wait_left_d  = WAIT_LOAD;
          end else begin
            mem_req = mem_access;
            if (ex_mdu_start && !mdu_done) begin
              pc_stall      = 1'b1;
              if_id_stall   = 1'b1;
              id_ex_stall   = 1'b1;
              ex_mem_bubble = 1'b1;
              state_d       = MDU_WAIT;
            end else if (ex_branch_taken) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_flush = 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (mem_resp_valid) begin
            state_d     = RUN;
            wait_left_d = '0;
          end else begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            if (wait_left_q == '0) state_d = ERR;
            else wait_left_d = wait_left_q - 1'b1;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_d = RUN;
          end else begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
          end
        end
        ERR: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_left_q <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_left_q <= wait_left_d;
      if (state_d == ERR) timeout_q <= 1'b1;
      if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout  = timeout_q;
  assign ctrl_state   = state_q;
  assign stall_cycles = stall_cnt_q;

endmodule
